// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - command, FIFO-read and output-stream bundle for fifo_burst_reader
interface fifo_burst_reader_if #(
  parameter int WIDTH     = 8,
  parameter int LEN_WIDTH = 8
);
  // Burst command
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [LEN_WIDTH-1:0] cmd_length;

  // Show-ahead FIFO read port
  logic                 fifo_empty;
  logic [WIDTH-1:0]     fifo_read_data;
  logic                 fifo_read_enable;

  // Output beat stream
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_last;

  // Status
  logic                 done;
  logic                 busy;

  // Reader side: consumes commands, pops the FIFO, drives the beat stream.
  modport master (
    input  cmd_valid, cmd_length, fifo_empty, fifo_read_data, out_ready,
    output cmd_ready, fifo_read_enable, out_valid, out_data, out_last, done, busy
  );

  // Environment side: issues commands, owns the FIFO, consumes beats.
  modport slave (
    output cmd_valid, cmd_length, fifo_empty, fifo_read_data, out_ready,
    input  cmd_ready, fifo_read_enable, out_valid, out_data, out_last, done, busy
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops a commanded number of words from a show-ahead FIFO onto a registered burst stream
module fifo_burst_reader #(
  parameter int WIDTH     = 8,
  parameter int LEN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_burst_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q;
  logic [LEN_WIDTH-1:0] remaining_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic                 out_last_q;
  logic                 done_q;

  logic                 beat_taken;
  logic                 last_word;
  logic                 pop;

  assign beat_taken = out_valid_q && bus.out_ready;
  assign last_word  = (remaining_q == LEN_WIDTH'(1));

  // The output register may be refilled when it is empty or being emptied this
  // cycle. The remaining_q guard keeps the counter from ever wrapping below zero.
  assign pop = (state_q == RUN) && !bus.fifo_empty &&
               (!out_valid_q || bus.out_ready) && (remaining_q != '0);

  // Command acceptance, FIFO-to-output capture and burst completion in one state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_length == '0) begin
              // Empty burst completes immediately without touching the FIFO.
              done_q <= 1'b1;
            end else begin
              remaining_q <= bus.cmd_length;
              state_q     <= RUN;
            end
          end
        end

        RUN: begin
          if (pop) begin
            out_data_q  <= bus.fifo_read_data;
            out_valid_q <= 1'b1;
            out_last_q  <= last_word;
            remaining_q <= remaining_q - LEN_WIDTH'(1);
            if (last_word) begin
              state_q <= DRAIN;
            end
          end else if (beat_taken) begin
            // FIFO ran dry while the held beat left: the stream goes idle until refilled.
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end

        DRAIN: begin
          if (beat_taken && out_last_q) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready        = (state_q == IDLE);
  assign bus.busy             = (state_q != IDLE);
  assign bus.fifo_read_enable = pop;
  assign bus.out_valid        = out_valid_q;
  assign bus.out_data         = out_data_q;
  assign bus.out_last         = out_last_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - randomized self-checking bench for fifo_burst_reader against a queue-based FIFO and stream model
module tb_fifo_burst_reader;

  logic clk;
  logic rst_n;

  fifo_burst_reader_if #(.WIDTH(8), .LEN_WIDTH(8)) bus ();

  fifo_burst_reader #(.WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO contents, and the words the stream still owes downstream in order.
  logic [7:0] fifo_q[$];
  logic [7:0] stream_q[$];

  int pops_seen    = 0;
  int pops_applied = 0;
  int done_count   = 0;
  int beat_total   = 0;
  int cyc          = 0;
  int ready_mode   = 0;

  int burst_len     = 0;
  int beat_in_burst = 0;
  int done_expect   = 0;
  int done_ref      = 0;
  int first_beat_cyc = 0;
  int last_beat_cyc  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    stream_q.push_back(w);
  endtask

  // FIFO model: applies pops observed last cycle, drives out_ready, presents the head word.
  initial begin
    bus.out_ready      = 1'b1;
    bus.fifo_empty     = 1'b1;
    bus.fifo_read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      while (pops_applied < pops_seen) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        pops_applied++;
      end
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      bus.fifo_empty     = (fifo_q.size() == 0);
      bus.fifo_read_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    end
  end

  // Monitor and scoreboard, sampled mid-cycle.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [7:0] exp_d;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        beat_in_burst = 0;
        burst_len     = 0;
        done_expect   = 0;
        prev_stall    = 1'b0;
      end else begin
        if (bus.fifo_empty) check("rd_en_while_empty", 32'(bus.fifo_read_enable), 0);
        if (bus.out_valid && !bus.out_ready) check("rd_en_while_stalled", 32'(bus.fifo_read_enable), 0);
        if (prev_stall) begin
          check("hold_valid", 32'(bus.out_valid), 1);
          check("hold_data", 32'(bus.out_data), 32'(prev_data));
          check("hold_last", 32'(bus.out_last), 32'(prev_last));
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;

        if (bus.fifo_read_enable) pops_seen++;

        if (bus.done) begin
          done_count++;
          check("done_expected", 32'(done_expect), 1);
          check("done_timing", 32'(cyc), 32'(done_ref + 1));
          check("done_busy_low", 32'(bus.busy), 0);
          check("done_burst_beats", 32'(beat_in_burst), 32'(burst_len));
          done_expect = 0;
        end

        if (bus.out_valid && bus.out_ready) begin
          beat_total++;
          if (beat_in_burst >= burst_len || stream_q.size() == 0) begin
            check("beat_unexpected", 1, 0);
          end else begin
            beat_in_burst++;
            exp_d = stream_q.pop_front();
            check("beat_data", 32'(bus.out_data), 32'(exp_d));
            check("beat_last", 32'(bus.out_last), 32'(beat_in_burst == burst_len));
            if (beat_in_burst == 1) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            if (beat_in_burst == burst_len) begin
              done_expect = 1;
              done_ref    = cyc;
            end
          end
        end

        if (bus.cmd_valid && bus.cmd_ready) begin
          burst_len     = int'(bus.cmd_length);
          beat_in_burst = 0;
          if (bus.cmd_length == 0) begin
            done_expect = 1;
            done_ref    = cyc;
          end
        end
      end
    end
  end

  task automatic issue_cmd(input int len);
    logic [31:0] lv;
    bit ok;
    ok = 1'b0;
    lv = 32'(len);
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_length = lv[7:0];
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_length = 8'($urandom);
    if (!ok) check("cmd_handshake_timeout", 0, 1);
  endtask

  task automatic wait_done(input int base, input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done_count > base) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int b0;
    int d0;
    int len;
    int k;
    int to_push;

    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_length = '0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_rd_en", 32'(bus.fifo_read_enable), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    idle(2);

    // Basic 4-word burst at full rate.
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    p0 = pops_seen; d0 = done_count;
    issue_cmd(4);
    wait_done(d0, 50);
    check("t1_pops", 32'(pops_seen - p0), 4);
    check("t1_span", 32'(last_beat_cyc - first_beat_cyc), 3);
    check("t1_single_done", 32'(done_count - d0), 1);
    idle(2);

    // Same burst with alternating backpressure.
    ready_mode = 1;
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    p0 = pops_seen; d0 = done_count;
    issue_cmd(4);
    wait_done(d0, 60);
    check("t2_pops", 32'(pops_seen - p0), 4);
    check("t2_stream_drained", 32'(stream_q.size()), 0);
    ready_mode = 0;
    idle(2);

    // FIFO underrun mid-burst.
    push(8'h31); push(8'h32);
    p0 = pops_seen; d0 = done_count;
    issue_cmd(6);
    idle(4);
    push(8'h33); push(8'h34); push(8'h35);
    idle(2);
    push(8'h36);
    wait_done(d0, 60);
    check("t3_pops", 32'(pops_seen - p0), 6);
    check("t3_single_done", 32'(done_count - d0), 1);
    idle(2);

    // Zero-length command.
    p0 = pops_seen; b0 = beat_total; d0 = done_count;
    issue_cmd(0);
    wait_done(d0, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_cmd_ready", 32'(bus.cmd_ready), 1);
    end
    check("t4_no_beats", 32'(beat_total - b0), 0);
    check("t4_no_pops", 32'(pops_seen - p0), 0);
    idle(1);

    // Maximum burst with the FIFO never running dry.
    for (int i = 0; i < 256; i++) push(8'($urandom));
    p0 = pops_seen; b0 = beat_total; d0 = done_count;
    issue_cmd(255);
    wait_done(d0, 400);
    check("t5_beats", 32'(beat_total - b0), 255);
    check("t5_span", 32'(last_beat_cyc - first_beat_cyc), 254);
    check("t5_pops", 32'(pops_seen - p0), 255);
    @(negedge clk);
    check("t5_busy_after", 32'(bus.busy), 0);
    idle(1);
    fifo_q.delete();
    stream_q.delete();
    idle(2);

    // Reset after two words have been popped.
    for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
    p0 = pops_seen;
    issue_cmd(4);
    for (int i = 0; i < 20; i++) begin
      if (pops_seen - p0 >= 2) break;
      @(negedge clk);
    end
    check("t6_pops_before_reset", 32'(pops_seen - p0), 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(bus.out_valid), 0);
    check("t6_rst_out_last", 32'(bus.out_last), 0);
    check("t6_rst_done", 32'(bus.done), 0);
    check("t6_rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("t6_fifo_left", 32'(fifo_q.size()), 2);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    stream_q = fifo_q;
    p0 = pops_seen; d0 = done_count;
    issue_cmd(2);
    wait_done(d0, 30);
    check("t6_resume_pops", 32'(pops_seen - p0), 2);
    check("t6_fifo_empty_after", 32'(fifo_q.size()), 0);
    idle(2);

    // Randomized bursts with random backpressure and random FIFO refill timing.
    ready_mode = 2;
    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(0, 20);
      k   = $urandom_range(0, len);
      for (int i = 0; i < k; i++) push(8'($urandom));
      to_push = len - k;
      p0 = pops_seen; d0 = done_count;
      issue_cmd(len);
      for (int c = 0; c < 400; c++) begin
        if (done_count > d0) break;
        @(posedge clk);
        #1;
        if (to_push > 0 && $urandom_range(0, 2) == 0) begin
          push(8'($urandom));
          to_push--;
        end
      end
      check("rand_done", 32'(done_count - d0), 1);
      check("rand_pops", 32'(pops_seen - p0), 32'(len));
      idle($urandom_range(0, 3));
    end
    ready_mode = 0;
    idle(3);
    check("final_stream_empty", 32'(stream_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
